store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
// Memory-stage store path, write-side counterpart of the write-back load extraction. Takes SB/SH/SW
// from execute, aligns data and byte enables to the word, buffers them in a small in-order FIFO and
// drains them to data memory over a req/gnt/ack handshake. Stalls the pipeline on a full buffer or
// on a load that hits a pending store word. No store-to-load forwarding.
// PARAMETERS
// DEPTH  2  store buffer entries (>=1); count width is $clog2(DEPTH+1)
// PORTS
// clk                       in   1   clock, all state updates on rising edge
// rst                       in   1   synchronous reset, active-high
// store_valid_from_execute  in   1   store instruction present this cycle
// load_from_execute         in   1   load instruction present this cycle (hazard check only)
// addr_from_execute         in   32  byte address of store or load
// data_from_execute         in   32  rs2 store data (unaligned, LSB-justified)
// funct3_from_execute       in   3   000 SB, 001 SH, 010 SW; others illegal
// stall_from_store          out  1   hold upstream stages this cycle
// misaligned_from_store     out  1   store dropped: misaligned or illegal funct3
// dmem_req                  out  1   memory write request
// dmem_addr                 out  32  word address, bits [1:0] always 00
// dmem_wdata                out  32  lane-replicated write data
// dmem_be                   out  4   byte enables
// dmem_gnt                  in   1   request accepted (sampled in REQ only)
// dmem_ack                  in   1   write complete (sampled in WAIT only)
// empty_from_store          out  1   buffer empty and FSM in IDLE
// BEHAVIOUR
// - Reset: FIFO flushed (count 0, pointers 0), FSM IDLE; dmem_req 0, dmem_be 0, dmem_addr 0,
//   dmem_wdata 0, stall 0, misaligned 0, empty 1. Applies mid-transaction; a late ack is ignored.
// - Formatting (off = addr[1:0]):
//   SB: be = 4'b0001<<off, wdata = {4{data[7:0]}}.
//   SH: off[0] must be 0; be = off[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
//   SW: off must be 00; be = 1111, wdata = data.
// - Illegal funct3 or bad alignment: misaligned_from_store = 1 combinationally in that cycle;
//   entry not written; does not stall.
// - Push: on edge when store_valid && legal && count<DEPTH. Full + store_valid -> stall=1, no push
//   (an entry popped that same cycle does not free space for it).
// - Load hazard: load_from_execute && any valid entry or in-flight head with
//   addr[31:2] == addr_from_execute[31:2] -> stall=1 until that entry is acked.
// - stall_from_store = (store_valid && legal && full) | load_hazard; combinational.
// - FSM IDLE: req 0; count>0 -> REQ.
//   REQ: req 1, addr/wdata/be = head, held stable until gnt; gnt -> WAIT.
//   WAIT: req 0; ack -> pop head; new count>0 -> REQ, else IDLE.
// - Head stays in FIFO until ack; a store is memory-visible no earlier than 2 cycles after push
//   (IDLE -> REQ takes one edge).
// - Push and pop on the same edge: count unchanged, pointers both advance, wrap modulo DEPTH.
// - dmem_addr/wdata/be drive 0 when req=0.
// TESTING
// - SB addr 0x103, data 0xA5 -> dmem_addr 0x100, be 1000, wdata 0xA5A5A5A5.
// - SH addr 0x202 data 0x1234 -> be 1100, wdata 0x12341234.
// - SH addr 0x201 -> misaligned=1, no req, empty stays 1.
// - SW addr 0x300 data 0xDEADBEEF, gnt +2 cycles, ack +3 -> req held 3 cycles stable, pops on ack.
// - DEPTH=2, three back-to-back SW with gnt/ack withheld -> 3rd stalls until first ack; FIFO order kept.
// - Pending SW 0x400, LW 0x402 -> stall until ack; LW 0x404 -> no stall.
// - Reset asserted in WAIT, then ack pulsed -> IDLE, empty=1, ack ignored, req=0.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: memory-stage store path. Aligns SB/SH/SW data and byte enables,
// queues them in an in-order buffer and drains them over a req/gnt/ack bus.
module store_unit #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_valid_from_execute,
  input  logic        load_from_execute,
  input  logic [31:0] addr_from_execute,
  input  logic [31:0] data_from_execute,
  input  logic [2:0]  funct3_from_execute,
  output logic        stall_from_store,
  output logic        misaligned_from_store,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_ack,
  output logic        empty_from_store
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  entry_t          r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [1:0]      w_off;
  logic            w_legal;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_hazard;
  entry_t          w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_off       = addr_from_execute[1:0];
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = store_valid_from_execute && w_legal && !w_full;
  assign w_pop       = (r_state == S_WAIT) && dmem_ack;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head      = r_mem[r_rd_ptr];

  assign misaligned_from_store = store_valid_from_execute && !w_legal;
  assign stall_from_store      = (store_valid_from_execute && w_legal && w_full) || w_hazard;
  assign empty_from_store      = (r_count == '0) && (r_state == S_IDLE);

  // Store formatting: lane-replicated data, byte enables, legality check
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (funct3_from_execute)
      3'b000: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{data_from_execute[7:0]}};
      end
      3'b001: begin
        w_legal = !w_off[0];
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_from_execute[15:0]}};
      end
      3'b010: begin
        w_legal = (w_off == 2'b00);
        w_be    = 4'b1111;
        w_wdata = data_from_execute;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Load hazard: load word matches any buffered store (head stays valid until ack)
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_vld[i] && (r_mem[i].waddr == addr_from_execute[31:2])) w_hazard = 1'b1;
    end
    w_hazard = w_hazard && load_from_execute;
  end

  // Drain FSM next state and bus outputs
  always_comb begin
    w_state_nxt = r_state;
    dmem_req    = 1'b0;
    dmem_addr   = 32'h0;
    dmem_wdata  = 32'h0;
    dmem_be     = 4'b0000;
    case (r_state)
      S_IDLE: if (r_count != '0) w_state_nxt = S_REQ;
      S_REQ: begin
        dmem_req   = 1'b1;
        dmem_addr  = {w_head.waddr, 2'b00};
        dmem_wdata = w_head.wdata;
        dmem_be    = w_head.be;
        if (dmem_gnt) w_state_nxt = S_WAIT;
      end
      S_WAIT: if (dmem_ack) w_state_nxt = (w_count_nxt != '0) ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Buffer control: pointers, count and per-entry valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= ptr_inc(r_rd_ptr);
      end
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      r_count <= w_count_nxt;
    end
  end

  // Buffer payload storage, qualified by the valid bits so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{waddr: addr_from_execute[31:2], wdata: w_wdata, be: w_be};
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sv;
  logic        ld;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  f3;
  logic        stall;
  logic        mis;
  logic        req;
  logic [31:0] maddr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        ack;
  logic        empty;

  int n_assert = 0;
  int n_fail   = 0;

  store_unit #(.DEPTH(2)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .store_valid_from_execute(sv),
    .load_from_execute       (ld),
    .addr_from_execute       (addr),
    .data_from_execute       (data),
    .funct3_from_execute     (f3),
    .stall_from_store        (stall),
    .misaligned_from_store   (mis),
    .dmem_req                (req),
    .dmem_addr               (maddr),
    .dmem_wdata              (wdata),
    .dmem_be                 (be),
    .dmem_gnt                (gnt),
    .dmem_ack                (ack),
    .empty_from_store        (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    sv = 1'b1; addr = a; data = d; f3 = f;
  endtask

  // Wait for a request, check payload held for gd cycles, grant, then ack after ad cycles
  task automatic drain_one(input string tag, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] wd, input int gd, input int ad);
    int k;
    k = 0;
    while (!req && k < 10) begin cyc(); k++; end
    chk({tag, "_req"}, 32'(req), 32'h1);
    for (int i = 0; i < gd; i++) begin
      chk({tag, "_hold_req"}, 32'(req), 32'h1);
      chk({tag, "_hold_addr"}, maddr, a);
      cyc();
    end
    chk({tag, "_addr"}, maddr, a);
    chk({tag, "_be"}, 32'(be), 32'(b));
    chk({tag, "_wdata"}, wdata, wd);
    gnt = 1'b1; cyc(); gnt = 1'b0;
    chk({tag, "_wait_req"}, 32'(req), 32'h0);
    chk({tag, "_wait_addr"}, maddr, 32'h0);
    for (int i = 0; i < ad - 1; i++) begin
      chk({tag, "_wait_req"}, 32'(req), 32'h0);
      cyc();
    end
    ack = 1'b1; cyc(); ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sv = 1'b0; ld = 1'b0; addr = '0; data = '0; f3 = '0; gnt = 1'b0; ack = 1'b0;
    cyc(); cyc();
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_be", 32'(be), 32'h0);
    chk("rst_addr", maddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mis", 32'(mis), 32'h0);
    rst = 1'b0;
    cyc();

    // SB to byte 3
    put(32'h103, 32'h777777A5, 3'b000); #1;
    chk("sb_mis", 32'(mis), 32'h0);
    chk("sb_stall", 32'(stall), 32'h0);
    cyc(); sv = 1'b0;
    chk("sb_idle_req", 32'(req), 32'h0);
    chk("sb_not_empty", 32'(empty), 32'h0);
    drain_one("sb", 32'h100, 4'b1000, 32'hA5A5A5A5, 0, 1);
    chk("sb_empty", 32'(empty), 32'h1);

    // SB to byte 1
    put(32'h101, 32'h0000003C, 3'b000);
    cyc(); sv = 1'b0;
    drain_one("sb1", 32'h100, 4'b0010, 32'h3C3C3C3C, 0, 1);

    // SH to upper half
    put(32'h202, 32'hABCD1234, 3'b001);
    cyc(); sv = 1'b0;
    drain_one("sh", 32'h200, 4'b1100, 32'h12341234, 1, 2);
    chk("sh_empty", 32'(empty), 32'h1);

    // Misaligned and illegal stores are dropped without stalling
    put(32'h201, 32'h1234, 3'b001); #1;
    chk("sh_mis", 32'(mis), 32'h1);
    chk("sh_mis_stall", 32'(stall), 32'h0);
    cyc();
    put(32'h302, 32'h1, 3'b010); #1;
    chk("sw_mis", 32'(mis), 32'h1);
    cyc();
    put(32'h300, 32'h1, 3'b011); #1;
    chk("ill_mis", 32'(mis), 32'h1);
    cyc(); sv = 1'b0; #1;
    chk("mis_clear", 32'(mis), 32'h0);
    cyc();
    chk("mis_no_req", 32'(req), 32'h0);
    chk("mis_empty", 32'(empty), 32'h1);

    // SW with delayed grant and ack
    put(32'h300, 32'hDEADBEEF, 3'b010);
    cyc(); sv = 1'b0;
    drain_one("sw", 32'h300, 4'b1111, 32'hDEADBEEF, 2, 3);
    chk("sw_empty", 32'(empty), 32'h1);

    // Three back-to-back SW into a two-entry buffer
    put(32'h500, 32'h1, 3'b010); #1;
    chk("q1_stall", 32'(stall), 32'h0);
    cyc();
    put(32'h504, 32'h2, 3'b010); #1;
    chk("q2_stall", 32'(stall), 32'h0);
    cyc();
    put(32'h508, 32'h3, 3'b010); #1;
    chk("q3_stall_a", 32'(stall), 32'h1);
    cyc();
    chk("q3_stall_b", 32'(stall), 32'h1);
    chk("q_head_addr", maddr, 32'h500);
    cyc();
    chk("q3_stall_c", 32'(stall), 32'h1);
    gnt = 1'b1; cyc(); gnt = 1'b0;
    chk("q3_stall_wait", 32'(stall), 32'h1);
    ack = 1'b1; #1;
    chk("q3_stall_ack", 32'(stall), 32'h1);
    cyc(); ack = 1'b0; #1;
    chk("q3_stall_free", 32'(stall), 32'h0);
    cyc(); sv = 1'b0;
    drain_one("q2", 32'h504, 4'b1111, 32'h2, 0, 1);
    drain_one("q3", 32'h508, 4'b1111, 32'h3, 0, 1);
    chk("q_empty", 32'(empty), 32'h1);

    // Load hazard against a pending store word
    put(32'h400, 32'hCAFEF00D, 3'b010);
    cyc(); sv = 1'b0;
    ld = 1'b1; addr = 32'h402; #1;
    chk("hz_stall", 32'(stall), 32'h1);
    addr = 32'h404; #1;
    chk("hz_other_word", 32'(stall), 32'h0);
    addr = 32'h402;
    cyc();
    chk("hz_req", 32'(req), 32'h1);
    chk("hz_addr", maddr, 32'h400);
    chk("hz_wdata", wdata, 32'hCAFEF00D);
    chk("hz_stall_req", 32'(stall), 32'h1);
    gnt = 1'b1; cyc(); gnt = 1'b0;
    chk("hz_stall_wait", 32'(stall), 32'h1);
    ack = 1'b1; #1;
    chk("hz_stall_ack", 32'(stall), 32'h1);
    cyc(); ack = 1'b0; #1;
    chk("hz_released", 32'(stall), 32'h0);
    chk("hz_empty", 32'(empty), 32'h1);
    ld = 1'b0;

    // Push and pop on the same edge
    put(32'h700, 32'h7, 3'b010);
    cyc(); sv = 1'b0;
    cyc();
    gnt = 1'b1; cyc(); gnt = 1'b0;
    put(32'h704, 32'h8, 3'b010); ack = 1'b1; #1;
    chk("pp_stall", 32'(stall), 32'h0);
    cyc(); sv = 1'b0; ack = 1'b0;
    chk("pp_not_empty", 32'(empty), 32'h0);
    drain_one("pp", 32'h704, 4'b1111, 32'h8, 0, 1);
    chk("pp_empty", 32'(empty), 32'h1);

    // Reset while waiting for ack, then a late ack
    put(32'h600, 32'h6, 3'b010);
    cyc(); sv = 1'b0;
    cyc();
    gnt = 1'b1; cyc(); gnt = 1'b0;
    chk("rw_in_wait", 32'(req), 32'h0);
    chk("rw_busy", 32'(empty), 32'h0);
    rst = 1'b1; cyc();
    rst = 1'b0; ack = 1'b1; cyc(); ack = 1'b0;
    chk("rw_empty", 32'(empty), 32'h1);
    chk("rw_req", 32'(req), 32'h0);
    chk("rw_be", 32'(be), 32'h0);
    cyc(); cyc();
    chk("rw_req_later", 32'(req), 32'h0);
    chk("rw_empty_later", 32'(empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
